sram_phase_sequencer: RTL and testbench

// - Top-level phase controller and SRAM arbiter: sequences UART image load -> milestone 2 decode
//   -> milestone 1 colour conversion -> VGA display.
// - Grants the single SRAM port to exactly one owner (UART, M2, M1, VGA) per phase.
// - Adds a per-phase watchdog and an error state. Replaces the ad-hoc top FSM in project.v.

---
 rtl/project_pkg.sv | 40 ++++
 rtl/sram_owner_mux.sv | 46 ++++
 rtl/sram_phase_sequencer.sv | 161 ++++++++++++++++
 tb/tb_sram_phase_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/project_pkg.sv
// Shared types and constants for the top-level phase sequencer and its SRAM owner mux.
package project_pkg;

  localparam int ADDR_W        = 18;
  localparam int DATA_W        = 16;
  localparam int UART_TIMER_W  = 26;
  localparam int PHASE_TIMER_W = 32;

  localparam logic [UART_TIMER_W-1:0]  UART_TIMEOUT_DEFAULT  = 26'd49999999;
  localparam logic [PHASE_TIMER_W-1:0] PHASE_TIMEOUT_DEFAULT = 32'd50000000;
  localparam logic [UART_TIMER_W-1:0]  SKIP_UART_DELAY       = 26'd10;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_UART_ARM = 4'd1,
    S_UART_RX  = 4'd2,
    S_M2_START = 4'd3,
    S_M2_RUN   = 4'd4,
    S_M1_START = 4'd5,
    S_M1_RUN   = 4'd6,
    S_ERROR    = 4'd7
  } seq_state_type;

  typedef enum logic [1:0] {
    OWN_VGA  = 2'd0,
    OWN_UART = 2'd1,
    OWN_M2   = 2'd2,
    OWN_M1   = 2'd3
  } sram_owner_type;

  function automatic sram_owner_type owner_for_state(input seq_state_type state);
    case (state)
      S_UART_ARM, S_UART_RX: return OWN_UART;
      S_M2_START, S_M2_RUN:  return OWN_M2;
      S_M1_START, S_M1_RUN:  return OWN_M1;
      default:               return OWN_VGA;
    endcase
  endfunction

endpackage

// File: rtl/sram_owner_mux.sv
// Routes exactly one client's address/data/strobe onto the single SRAM port.
module sram_owner_mux
  import project_pkg::*;
(
  input  sram_owner_type    owner,
  input  logic [ADDR_W-1:0] VGA_SRAM_address,
  input  logic [ADDR_W-1:0] UART_SRAM_address,
  input  logic [DATA_W-1:0] UART_SRAM_write_data,
  input  logic              UART_SRAM_we_n,
  input  logic [ADDR_W-1:0] M2_SRAM_address,
  input  logic [DATA_W-1:0] M2_SRAM_write_data,
  input  logic              M2_SRAM_we_n,
  input  logic [ADDR_W-1:0] M1_SRAM_address,
  input  logic [DATA_W-1:0] M1_SRAM_write_data,
  input  logic              M1_SRAM_we_n,
  output logic [ADDR_W-1:0] SRAM_address,
  output logic [DATA_W-1:0] SRAM_write_data,
  output logic              SRAM_we_n
);

  // VGA only reads, so its slot keeps the strobe high and parks UART data on the bus.
  always_comb begin
    SRAM_address    = VGA_SRAM_address;
    SRAM_write_data = UART_SRAM_write_data;
    SRAM_we_n       = 1'b1;
    case (owner)
      OWN_UART: begin
        SRAM_address    = UART_SRAM_address;
        SRAM_write_data = UART_SRAM_write_data;
        SRAM_we_n       = UART_SRAM_we_n;
      end
      OWN_M2: begin
        SRAM_address    = M2_SRAM_address;
        SRAM_write_data = M2_SRAM_write_data;
        SRAM_we_n       = M2_SRAM_we_n;
      end
      OWN_M1: begin
        SRAM_address    = M1_SRAM_address;
        SRAM_write_data = M1_SRAM_write_data;
        SRAM_we_n       = M1_SRAM_we_n;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sram_phase_sequencer.sv
// Phase controller: UART load -> M2 decode -> M1 colour convert -> VGA display,
// with a per-phase watchdog and a sticky error state.
module sram_phase_sequencer
  import project_pkg::*;
#(
  parameter logic [UART_TIMER_W-1:0]  UART_TIMEOUT  = UART_TIMEOUT_DEFAULT,
  parameter logic [PHASE_TIMER_W-1:0] PHASE_TIMEOUT = PHASE_TIMEOUT_DEFAULT,
  parameter logic                     SKIP_UART     = 1'b0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              UART_RX_I,
  input  logic              start_pb,
  input  logic [ADDR_W-1:0] UART_SRAM_address,
  input  logic [DATA_W-1:0] UART_SRAM_write_data,
  input  logic              UART_SRAM_we_n,
  output logic              UART_rx_initialize,
  output logic              UART_rx_enable,
  output logic              M2_start,
  output logic              M1_start,
  input  logic              M2_done,
  input  logic              M1_done,
  input  logic [ADDR_W-1:0] M2_SRAM_address,
  input  logic [DATA_W-1:0] M2_SRAM_write_data,
  input  logic              M2_SRAM_we_n,
  input  logic [ADDR_W-1:0] M1_SRAM_address,
  input  logic [DATA_W-1:0] M1_SRAM_write_data,
  input  logic              M1_SRAM_we_n,
  input  logic [ADDR_W-1:0] VGA_SRAM_address,
  output logic              VGA_enable,
  output logic [ADDR_W-1:0] SRAM_address,
  output logic [DATA_W-1:0] SRAM_write_data,
  output logic              SRAM_we_n,
  output logic [3:0]        seq_state,
  output logic              phase_error
);

  seq_state_type            state, state_next;
  sram_owner_type           owner;
  logic [UART_TIMER_W-1:0]  uart_timer;
  logic [PHASE_TIMER_W-1:0] phase_timer;
  logic m2_start_next, m1_start_next, rx_init_next, rx_enable_next;
  logic vga_enable_next, phase_error_next, phase_expired;

  assign seq_state     = state;
  assign phase_expired = (phase_timer == PHASE_TIMEOUT);

  always_comb begin
    state_next       = state;
    m2_start_next    = 1'b0;
    m1_start_next    = 1'b0;
    rx_init_next     = 1'b0;
    rx_enable_next   = 1'b0;
    vga_enable_next  = VGA_enable;
    phase_error_next = phase_error;
    case (state)
      S_IDLE: begin
        if (!UART_RX_I || start_pb) begin
          state_next      = S_UART_ARM;
          rx_init_next    = 1'b1;
          vga_enable_next = 1'b0;
        end else if (SKIP_UART && uart_timer == SKIP_UART_DELAY) begin
          state_next      = S_M2_START;
          m2_start_next   = 1'b1;
          vga_enable_next = 1'b0;
        end
      end
      S_UART_ARM: begin
        state_next     = S_UART_RX;
        rx_enable_next = 1'b1;
      end
      S_UART_RX: begin
        // An empty image (writer never advanced) does not count as a finished load.
        if (uart_timer == UART_TIMEOUT && UART_SRAM_address != '0) begin
          state_next    = S_M2_START;
          m2_start_next = 1'b1;
          rx_init_next  = 1'b1;
        end
      end
      S_M2_START, S_M2_RUN: begin
        if (M2_done) begin
          state_next    = S_M1_START;
          m1_start_next = 1'b1;
        end else if (phase_expired) begin
          state_next       = S_ERROR;
          vga_enable_next  = 1'b1;
          phase_error_next = 1'b1;
        end else begin
          state_next = S_M2_RUN;
        end
      end
      S_M1_START, S_M1_RUN: begin
        if (M1_done) begin
          state_next      = S_IDLE;
          vga_enable_next = 1'b1;
        end else if (phase_expired) begin
          state_next       = S_ERROR;
          vga_enable_next  = 1'b1;
          phase_error_next = 1'b1;
        end else begin
          state_next = S_M1_RUN;
        end
      end
      S_ERROR: begin
        vga_enable_next  = 1'b1;
        phase_error_next = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state              <= S_IDLE;
      owner              <= OWN_VGA;
      M2_start           <= 1'b0;
      M1_start           <= 1'b0;
      UART_rx_initialize <= 1'b0;
      UART_rx_enable     <= 1'b0;
      VGA_enable         <= 1'b1;
      phase_error        <= 1'b0;
      uart_timer         <= '0;
      phase_timer        <= '0;
    end else begin
      state              <= state_next;
      owner              <= owner_for_state(state_next);
      M2_start           <= m2_start_next;
      M1_start           <= m1_start_next;
      UART_rx_initialize <= rx_init_next;
      UART_rx_enable     <= rx_enable_next;
      VGA_enable         <= vga_enable_next;
      phase_error        <= phase_error_next;
      if (UART_rx_initialize || !UART_SRAM_we_n)
        uart_timer <= '0;
      else if (uart_timer != '1)
        uart_timer <= uart_timer + 1'b1;
      if (state_next == S_M2_START || state_next == S_M1_START)
        phase_timer <= '0;
      else if (state == S_M2_RUN || state == S_M1_RUN)
        phase_timer <= phase_timer + 1'b1;
    end
  end

  sram_owner_mux u_owner_mux (
    .owner               (owner),
    .VGA_SRAM_address    (VGA_SRAM_address),
    .UART_SRAM_address   (UART_SRAM_address),
    .UART_SRAM_write_data(UART_SRAM_write_data),
    .UART_SRAM_we_n      (UART_SRAM_we_n),
    .M2_SRAM_address     (M2_SRAM_address),
    .M2_SRAM_write_data  (M2_SRAM_write_data),
    .M2_SRAM_we_n        (M2_SRAM_we_n),
    .M1_SRAM_address     (M1_SRAM_address),
    .M1_SRAM_write_data  (M1_SRAM_write_data),
    .M1_SRAM_we_n        (M1_SRAM_we_n),
    .SRAM_address        (SRAM_address),
    .SRAM_write_data     (SRAM_write_data),
    .SRAM_we_n           (SRAM_we_n)
  );

endmodule

// File: tb/tb_sram_phase_sequencer.sv
// Scoreboard bench for sram_phase_sequencer: one main instance and one SKIP_UART instance.
module tb_sram_phase_sequencer;

  localparam int UT = 20;
  localparam int PT = 100;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_ARM = 4'd1, ST_RX  = 4'd2, ST_M2S = 4'd3,
                         ST_M2R  = 4'd4, ST_M1S = 4'd5, ST_M1R = 4'd6, ST_ERR = 4'd7;
  // flag order: {VGA_enable, phase_error, M2_start, M1_start, UART_rx_initialize, UART_rx_enable}
  localparam logic [5:0] F_NONE = 6'b000000, F_VGA = 6'b100000, F_ERR = 6'b010000,
                         F_M2S  = 6'b001000, F_M1S = 6'b000100, F_INIT = 6'b000010,
                         F_EN   = 6'b000001;

  typedef struct packed {
    logic [3:0]  st;
    logic [5:0]  fl;
    logic [17:0] addr;
    logic [15:0] wd;
    logic        we;
  } snap_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        UART_RX_I = 1'b1;
  logic        start_pb = 1'b0;
  logic [17:0] uart_addr = '0;
  logic [15:0] uart_wd = '0;
  logic        uart_we_n = 1'b1;
  logic        m2_done = 1'b0, m1_done = 1'b0;
  logic [17:0] m2_addr = 18'h22222, m1_addr = 18'h33333, vga_addr = 18'h11111;
  logic [15:0] m2_wd = 16'h2222, m1_wd = 16'h3333;
  logic        m2_we_n = 1'b1, m1_we_n = 1'b1;

  logic        UART_rx_initialize, UART_rx_enable, M2_start, M1_start, VGA_enable;
  logic        SRAM_we_n, phase_error;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic [3:0]  seq_state;

  logic        sk_rst = 1'b1;
  logic        sk_init, sk_en, sk_m2s, sk_m1s, sk_vga, sk_we, sk_err;
  logic [17:0] sk_addr;
  logic [15:0] sk_wd;
  logic [3:0]  sk_state;

  snap_t exp_q[$];
  snap_t got, expv;
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 Clock = ~Clock;

  sram_phase_sequencer #(.UART_TIMEOUT(26'd20), .PHASE_TIMEOUT(32'd100), .SKIP_UART(1'b0)) dut (
    .Clock(Clock), .Reset(Reset), .UART_RX_I(UART_RX_I), .start_pb(start_pb),
    .UART_SRAM_address(uart_addr), .UART_SRAM_write_data(uart_wd), .UART_SRAM_we_n(uart_we_n),
    .UART_rx_initialize(UART_rx_initialize), .UART_rx_enable(UART_rx_enable),
    .M2_start(M2_start), .M1_start(M1_start), .M2_done(m2_done), .M1_done(m1_done),
    .M2_SRAM_address(m2_addr), .M2_SRAM_write_data(m2_wd), .M2_SRAM_we_n(m2_we_n),
    .M1_SRAM_address(m1_addr), .M1_SRAM_write_data(m1_wd), .M1_SRAM_we_n(m1_we_n),
    .VGA_SRAM_address(vga_addr), .VGA_enable(VGA_enable),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
    .seq_state(seq_state), .phase_error(phase_error)
  );

  sram_phase_sequencer #(.UART_TIMEOUT(26'd20), .PHASE_TIMEOUT(32'd100), .SKIP_UART(1'b1)) dut_skip (
    .Clock(Clock), .Reset(sk_rst), .UART_RX_I(1'b1), .start_pb(1'b0),
    .UART_SRAM_address(18'h0), .UART_SRAM_write_data(16'h0000), .UART_SRAM_we_n(1'b1),
    .UART_rx_initialize(sk_init), .UART_rx_enable(sk_en),
    .M2_start(sk_m2s), .M1_start(sk_m1s), .M2_done(1'b0), .M1_done(1'b0),
    .M2_SRAM_address(18'h0BEEF), .M2_SRAM_write_data(16'h1234), .M2_SRAM_we_n(1'b1),
    .M1_SRAM_address(18'h0CAFE), .M1_SRAM_write_data(16'h5678), .M1_SRAM_we_n(1'b0),
    .VGA_SRAM_address(18'h0ABCD), .VGA_enable(sk_vga),
    .SRAM_address(sk_addr), .SRAM_write_data(sk_wd), .SRAM_we_n(sk_we),
    .seq_state(sk_state), .phase_error(sk_err)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic snap_t snap_main();
    return {seq_state, VGA_enable, phase_error, M2_start, M1_start, UART_rx_initialize,
            UART_rx_enable, SRAM_address, SRAM_write_data, SRAM_we_n};
  endfunction

  function automatic snap_t snap_skip();
    return {sk_state, sk_vga, sk_err, sk_m2s, sk_m1s, sk_init, sk_en, sk_addr, sk_wd, sk_we};
  endfunction

  // Expected SRAM port for an owner: 0 VGA, 1 UART, 2 M2, 3 M1 (main instance inputs).
  function automatic logic [34:0] bus_for(input int own);
    case (own)
      1:       return {uart_addr, uart_wd, uart_we_n};
      2:       return {m2_addr, m2_wd, m2_we_n};
      3:       return {m1_addr, m1_wd, m1_we_n};
      default: return {vga_addr, uart_wd, 1'b1};
    endcase
  endfunction

  function automatic snap_t mk(input logic [3:0] st, input logic [5:0] fl, input logic [34:0] bus);
    return {st, fl, bus};
  endfunction

  // Unchecked driver: IDLE -> pb -> 4 UART writes -> idle until timeout; lands in S_M2_START.
  task automatic drive_to_m2_start();
    start_pb = 1'b1; tick(); start_pb = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      uart_addr = 18'(i); uart_wd = 16'(16'hB000 + i); uart_we_n = 1'b0;
      tick();
    end
    uart_we_n = 1'b1; uart_addr = 18'd4;
    repeat (UT + 1) tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    exp_q.push_back(mk(ST_IDLE, F_VGA, bus_for(0)));
    tick();
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL reset_state: actual=%h required=%h", got, expv); end
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vga_addr = 18'(18'h11111 + i);
      exp_q.push_back(mk(ST_IDLE, F_VGA, bus_for(0)));
      tick();
      got = snap_main(); expv = exp_q.pop_front(); n_tests++;
      if (got !== expv) begin n_fail++; $display("FAIL idle_hold[%0d]: actual=%h required=%h", i, got, expv); end
    end
  endtask

  task automatic test_uart_arm();
    start_pb = 1'b1;
    exp_q.push_back(mk(ST_ARM, F_INIT, bus_for(1)));
    tick();
    start_pb = 1'b0;
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL pb_to_arm: actual=%h required=%h", got, expv); end
    exp_q.push_back(mk(ST_RX, F_EN, bus_for(1)));
    tick();
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL arm_to_rx: actual=%h required=%h", got, expv); end
  endtask

  task automatic test_uart_zero_addr();
    start_pb = 1'b1;
    exp_q.push_back(mk(ST_RX, F_NONE, bus_for(1)));
    tick();
    start_pb = 1'b0;
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL pb_ignored_rx: actual=%h required=%h", got, expv); end
    // timer reaches UT with address 0 two edges before the check below
    repeat (UT) tick();
    exp_q.push_back(mk(ST_RX, F_NONE, bus_for(1)));
    tick();
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL zero_addr_timeout: actual=%h required=%h", got, expv); end
  endtask

  task automatic test_uart_load();
    for (int i = 0; i < 4; i++) begin
      uart_addr = 18'(i); uart_wd = 16'(16'hA000 + i); uart_we_n = 1'b0;
      exp_q.push_back(mk(ST_RX, F_NONE, bus_for(1)));
      tick();
      got = snap_main(); expv = exp_q.pop_front(); n_tests++;
      if (got !== expv) begin n_fail++; $display("FAIL uart_write[%0d]: actual=%h required=%h", i, got, expv); end
    end
    uart_we_n = 1'b1; uart_addr = 18'd4;
    repeat (UT - 1) tick();
    exp_q.push_back(mk(ST_RX, F_NONE, bus_for(1)));
    tick();
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL uart_idle_last: actual=%h required=%h", got, expv); end
    exp_q.push_back(mk(ST_M2S, F_M2S | F_INIT, bus_for(2)));
    tick();
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL uart_timeout_m2_start: actual=%h required=%h", got, expv); end
    exp_q.push_back(mk(ST_M2R, F_NONE, bus_for(2)));
    tick();
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL m2_start_drops: actual=%h required=%h", got, expv); end
  endtask

  task automatic test_m2_mux_and_done();
    m1_we_n = 1'b0; m2_we_n = 1'b1;
    exp_q.push_back(mk(ST_M2R, F_NONE, bus_for(2)));
    tick();
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL m2_nonowner_we: actual=%h required=%h", got, expv); end
    m2_we_n = 1'b0; m2_addr = 18'h2ABCD; m2_wd = 16'h5A5A;
    exp_q.push_back(mk(ST_M2R, F_NONE, bus_for(2)));
    tick();
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL m2_owner_we: actual=%h required=%h", got, expv); end
    m2_we_n = 1'b1; m2_done = 1'b1;
    exp_q.push_back(mk(ST_M1S, F_M1S, bus_for(3)));
    tick();
    m2_done = 1'b0;
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL m2_done_m1_start: actual=%h required=%h", got, expv); end
    exp_q.push_back(mk(ST_M1R, F_NONE, bus_for(3)));
    tick();
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL m1_run: actual=%h required=%h", got, expv); end
  endtask

  task automatic test_m1_done();
    m1_we_n = 1'b1; m1_done = 1'b1;
    exp_q.push_back(mk(ST_IDLE, F_VGA, bus_for(0)));
    tick();
    m1_done = 1'b0;
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL m1_done_idle: actual=%h required=%h", got, expv); end
    exp_q.push_back(mk(ST_IDLE, F_VGA, bus_for(0)));
    tick();
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL idle_after_m1: actual=%h required=%h", got, expv); end
  endtask

  task automatic test_back_to_back();
    drive_to_m2_start();
    m2_done = 1'b1;
    exp_q.push_back(mk(ST_M1S, F_M1S, bus_for(3)));
    tick();
    m2_done = 1'b0;
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL done_in_m2_start: actual=%h required=%h", got, expv); end
    m1_done = 1'b1;
    exp_q.push_back(mk(ST_IDLE, F_VGA, bus_for(0)));
    tick();
    m1_done = 1'b0;
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL done_in_m1_start: actual=%h required=%h", got, expv); end
  endtask

  // M2_START at edge s; RUN from s+1 with timer 0, timer==PT visible during the cycle after s+1+PT.
  task automatic test_done_beats_timeout();
    drive_to_m2_start();
    repeat (PT) tick();
    exp_q.push_back(mk(ST_M2R, F_NONE, bus_for(2)));
    tick();
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL run_before_limit: actual=%h required=%h", got, expv); end
    m2_done = 1'b1;
    exp_q.push_back(mk(ST_M1S, F_M1S, bus_for(3)));
    tick();
    m2_done = 1'b0;
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL done_beats_timeout: actual=%h required=%h", got, expv); end
    m1_done = 1'b1;
    tick();
    m1_done = 1'b0;
  endtask

  task automatic test_timeout_error();
    drive_to_m2_start();
    repeat (PT) tick();
    exp_q.push_back(mk(ST_M2R, F_NONE, bus_for(2)));
    tick();
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL run_at_limit: actual=%h required=%h", got, expv); end
    exp_q.push_back(mk(ST_ERR, F_VGA | F_ERR, bus_for(0)));
    tick();
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL timeout_error: actual=%h required=%h", got, expv); end
    m2_done = 1'b1; start_pb = 1'b1; UART_RX_I = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(ST_ERR, F_VGA | F_ERR, bus_for(0)));
      tick();
      got = snap_main(); expv = exp_q.pop_front(); n_tests++;
      if (got !== expv) begin n_fail++; $display("FAIL error_sticky[%0d]: actual=%h required=%h", i, got, expv); end
    end
    m2_done = 1'b0; start_pb = 1'b0; UART_RX_I = 1'b1;
    Reset = 1'b1;
    exp_q.push_back(mk(ST_IDLE, F_VGA, bus_for(0)));
    tick();
    Reset = 1'b0;
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL error_reset_clears: actual=%h required=%h", got, expv); end
  endtask

  task automatic test_reset_mid_phase();
    drive_to_m2_start();
    m2_done = 1'b1; tick(); m2_done = 1'b0;
    m1_we_n = 1'b0;
    exp_q.push_back(mk(ST_M1R, F_NONE, bus_for(3)));
    tick();
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL in_m1_run: actual=%h required=%h", got, expv); end
    Reset = 1'b1;
    exp_q.push_back(mk(ST_IDLE, F_VGA, bus_for(0)));
    tick();
    Reset = 1'b0; m1_we_n = 1'b1;
    got = snap_main(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL reset_mid_m1: actual=%h required=%h", got, expv); end
  endtask

  // Reset sampled at edge e0; uart_timer is 10 after e10, so M2_start appears at e11.
  task automatic test_skip_uart();
    sk_rst = 1'b1;
    tick();
    sk_rst = 1'b0;
    repeat (9) tick();
    exp_q.push_back(mk(ST_IDLE, F_VGA, {18'h0ABCD, 16'h0000, 1'b1}));
    tick();
    got = snap_skip(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL skip_idle_c10: actual=%h required=%h", got, expv); end
    exp_q.push_back(mk(ST_M2S, F_M2S, {18'h0BEEF, 16'h1234, 1'b1}));
    tick();
    got = snap_skip(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL skip_m2_start_c11: actual=%h required=%h", got, expv); end
    exp_q.push_back(mk(ST_M2R, F_NONE, {18'h0BEEF, 16'h1234, 1'b1}));
    tick();
    got = snap_skip(); expv = exp_q.pop_front(); n_tests++;
    if (got !== expv) begin n_fail++; $display("FAIL skip_m2_run: actual=%h required=%h", got, expv); end
  endtask

  initial begin
    test_reset();
    test_uart_arm();
    test_uart_zero_addr();
    test_uart_load();
    test_m2_mux_and_done();
    test_m1_done();
    test_back_to_back();
    test_done_beats_timeout();
    test_timeout_error();
    test_reset_mid_phase();
    test_skip_uart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
